// File: rtl/viterbi_pkg.sv
// Shared definitions for the Viterbi decode path.
//   - vfc_state_e        : frame controller state encoding (IDLE must stay 0)
//   - VITERBI_TBLEN      : decoder traceback depth / flush symbol count
//   - VITERBI_FRAME_BITS : encoded symbols per frame = decoded bits per frame
package viterbi_pkg;

    localparam int VITERBI_TBLEN      = 32;
    localparam int VITERBI_FRAME_BITS = 512;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_FLUSH = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } vfc_state_e;

endpackage

// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer in front of viterbi_decoder. It loads FRAME_BITS encoded
// symbols, appends TBLEN zero flush symbols, and forwards exactly FRAME_BITS
// decoded bits with a last marker and a done pulse.
//
// Optional build macro: VITERBI_FRAME_TIMEOUT_EN adds a DRAIN watchdog
// (TIMEOUT_CYC cycles) that aborts the frame with an err_timeout pulse.
//
// Ports:
//   clk, RSTn               clock, async active-low reset
//   start                   frame request, honoured only in IDLE
//   s_valid/s_data/s_ready  upstream encoded symbol handshake
//   dec_in_valid/dec_in     symbols to the decoder (registered)
//   dec_out_valid/dec_out   decoded bits from the decoder
//   m_valid/m_data/m_last   decoded bit stream, no backpressure
//   busy, done, err_timeout status
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | accepting source symbols, passing them to the decoder
// FLUSH | feeding TBLEN zero symbols to push out the traceback
// DRAIN | waiting for the remaining decoded bits
// DONE  | one-cycle completion pulse
module viterbi_frame_ctrl
    import viterbi_pkg::*;
#(
    parameter int FRAME_BITS  = VITERBI_FRAME_BITS,
    parameter int TBLEN       = VITERBI_TBLEN
`ifdef VITERBI_FRAME_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 4096
`endif
) (
    input  logic       clk,
    input  logic       RSTn,
    input  logic       start,
    input  logic       s_valid,
    input  logic [1:0] s_data,
    output logic       s_ready,
    output logic       dec_in_valid,
    output logic [1:0] dec_in,
    input  logic       dec_out_valid,
    input  logic       dec_out,
    output logic       m_valid,
    output logic       m_data,
    output logic       m_last,
    output logic       busy,
    output logic       done,
    output logic       err_timeout
);

    localparam int CW = $clog2(FRAME_BITS + 1);
    localparam int FW = $clog2(TBLEN + 1);

    localparam logic [CW-1:0] FRAME_N  = CW'(FRAME_BITS);
    localparam logic [CW-1:0] FRAME_M1 = CW'(FRAME_BITS - 1);
    localparam logic [FW-1:0] FLUSH_N  = FW'(TBLEN);
    localparam logic [FW-1:0] FLUSH_M1 = FW'(TBLEN - 1);

    vfc_state_e    state, state_nxt;
    logic [CW-1:0] in_cnt;
    logic [CW-1:0] out_cnt;
    logic [FW-1:0] flush_cnt;
    logic          accept;
    logic          fwd;
    logic          wd_expire;

    assign accept = s_valid && (state == ST_LOAD);
    assign fwd    = dec_out_valid && (out_cnt < FRAME_N) &&
                    ((state == ST_LOAD) || (state == ST_FLUSH) || (state == ST_DRAIN));
    assign busy   = (state != ST_IDLE);

    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                s_ready = 1'b1;
                if (s_valid && (in_cnt == FRAME_M1)) state_nxt = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (flush_cnt == FLUSH_M1)
                    state_nxt = (out_cnt == FRAME_N) ? ST_DONE : ST_DRAIN;
            end
            ST_DRAIN: begin
                if (out_cnt == FRAME_N) state_nxt = ST_DONE;
                else if (wd_expire)     state_nxt = ST_IDLE;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            state        <= ST_IDLE;
            in_cnt       <= '0;
            out_cnt      <= '0;
            flush_cnt    <= '0;
            dec_in_valid <= 1'b0;
            dec_in       <= 2'b00;
            m_valid      <= 1'b0;
            m_data       <= 1'b0;
            m_last       <= 1'b0;
        end else begin
            state        <= state_nxt;
            dec_in_valid <= 1'b0;
            m_valid      <= 1'b0;
            m_last       <= 1'b0;

            if ((state == ST_IDLE && start) || wd_expire) begin
                in_cnt    <= '0;
                out_cnt   <= '0;
                flush_cnt <= '0;
            end else begin
                if (accept) begin
                    dec_in_valid <= 1'b1;
                    dec_in       <= s_data;
                    if (in_cnt != FRAME_N) in_cnt <= in_cnt + CW'(1);
                end

                if (state == ST_FLUSH) begin
                    dec_in_valid <= 1'b1;
                    dec_in       <= 2'b00;
                    if (flush_cnt != FLUSH_N) flush_cnt <= flush_cnt + FW'(1);
                end

                // fwd already excludes out_cnt == FRAME_N, so this saturates
                if (fwd) begin
                    m_valid <= 1'b1;
                    m_data  <= dec_out;
                    m_last  <= (out_cnt == FRAME_M1);
                    out_cnt <= out_cnt + CW'(1);
                end
            end
        end
    end

`ifdef VITERBI_FRAME_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WW-1:0] WD_LOAD = WW'(TIMEOUT_CYC - 1);

    logic [WW-1:0] wd_cnt;

    // Down-counter reloaded outside DRAIN; terminal count is the
    // TIMEOUT_CYC-th DRAIN cycle, unless the frame completes that cycle.
    assign wd_expire = (state == ST_DRAIN) && (wd_cnt == '0) && (out_cnt != FRAME_N);

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            wd_cnt      <= WD_LOAD;
            err_timeout <= 1'b0;
        end else begin
            err_timeout <= wd_expire;
            if (state != ST_DRAIN)  wd_cnt <= WD_LOAD;
            else if (wd_cnt != '0)  wd_cnt <= wd_cnt - WW'(1);
        end
    end
`else
    assign wd_expire   = 1'b0;
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Self-checking bench for viterbi_frame_ctrl with a queue-based decoder model
// (ideal decoder: bit k leaves once symbol k+TBLEN has entered).
module tb_viterbi_frame_ctrl;
    import viterbi_pkg::*;

    localparam int FB = VITERBI_FRAME_BITS;
    localparam int TB = VITERBI_TBLEN;

    logic       clk = 1'b0;
    logic       RSTn = 1'b0;
    logic       start = 1'b0;
    logic       s_valid = 1'b0;
    logic [1:0] s_data = 2'b00;
    logic       dec_out_valid = 1'b0;
    logic       dec_out = 1'b0;
    logic       s_ready, dec_in_valid, m_valid, m_data, m_last, busy, done, err_timeout;
    logic [1:0] dec_in;

    viterbi_frame_ctrl dut (
        .clk           (clk),
        .RSTn          (RSTn),
        .start         (start),
        .s_valid       (s_valid),
        .s_data        (s_data),
        .s_ready       (s_ready),
        .dec_in_valid  (dec_in_valid),
        .dec_in        (dec_in),
        .dec_out_valid (dec_out_valid),
        .dec_out       (dec_out),
        .m_valid       (m_valid),
        .m_data        (m_data),
        .m_last        (m_last),
        .busy          (busy),
        .done          (done),
        .err_timeout   (err_timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- decoder model ----------------
    logic [1:0] dq[$];
    logic [1:0] dsym;
    int         dec_emitted = 0;
    int         dec_limit   = FB;
    int         dec_extra   = 0;

    always @(negedge clk) begin
        if (!RSTn) begin
            dq.delete();
            dec_out_valid = 1'b0;
            dec_out       = 1'b0;
        end else begin
            dec_out_valid = 1'b0;
            if (dec_in_valid) dq.push_back(dec_in);
            if (dq.size() > TB && dec_emitted < dec_limit) begin
                dsym          = dq.pop_front();
                dec_out       = dsym[0] ^ dsym[1];
                dec_out_valid = 1'b1;
                dec_emitted++;
            end else if (dec_emitted >= FB && dec_extra > 0) begin
                dec_out       = 1'($urandom);
                dec_out_valid = 1'b1;
                dec_extra--;
            end
        end
    end

    // ---------------- output monitor ----------------
    logic [1:0] dec_q[$];
    bit         got[$];
    int         cyc = 0;
    int         last_cnt, last_idx, last_cyc, done_cnt, done_cyc;
    int         run, max_run, lat_bad, err_cnt, err_cyc, dec_last_cyc;
    bit         hs_prev, rdy_prev;
    logic [1:0] sym_prev;

    always @(negedge clk) begin
        cyc++;
        if (!RSTn) begin
            hs_prev  = 1'b0;
            rdy_prev = 1'b0;
            run      = 0;
        end else begin
            if (m_valid) got.push_back(m_data);
            if (m_last) begin
                last_cnt++;
                last_idx = got.size();
                last_cyc = cyc;
                if (!m_valid) lat_bad++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (err_timeout) begin
                err_cnt++;
                err_cyc = cyc;
            end
            if (dec_in_valid) begin
                dec_q.push_back(dec_in);
                dec_last_cyc = cyc;
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            // during LOAD dec_in_valid must echo the previous cycle's handshake
            if (hs_prev && (!dec_in_valid || dec_in !== sym_prev)) lat_bad++;
            if (rdy_prev && !hs_prev && dec_in_valid) lat_bad++;
            hs_prev  = s_valid && s_ready;
            rdy_prev = s_ready;
            sym_prev = s_data;
        end
    end

    logic [1:0] exp_syms[$];

    task automatic clear_all(input int extra, input int limit);
        dq.delete();
        dec_emitted = 0;
        dec_extra   = extra;
        dec_limit   = limit;
        dec_q.delete();
        got.delete();
        exp_syms.delete();
        last_cnt = 0; last_idx = 0; last_cyc = 0;
        done_cnt = 0; done_cyc = 0;
        run = 0; max_run = 0; lat_bad = 0;
        err_cnt = 0; err_cyc = 0; dec_last_cyc = 0;
    endtask

    task automatic send_frame(input int mode, input int poke_at, input int rst_at,
                              input string tag, output bit aborted);
        int  sent;
        int  budget;
        bit  v;
        bit  acc;
        aborted = 1'b0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        sent   = 0;
        budget = 0;
        while (sent < FB && budget < 4 * FB) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (budget % 2 == 0);
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            s_valid = v;
            s_data  = 2'($urandom);
            start   = (poke_at >= 0 && sent == poke_at);
            acc     = v && s_ready;
            @(posedge clk); #1;
            if (acc) begin
                exp_syms.push_back(s_data);
                sent++;
            end
            budget++;
            if (rst_at >= 0 && sent == rst_at) begin
                s_valid = 1'b0;
                start   = 1'b0;
                #1 RSTn = 1'b0;
                #1;
                chk({tag, "_rst_outs"},
                    32'({s_ready, dec_in_valid, dec_in, m_valid, m_data, m_last, busy, done, err_timeout}),
                    32'd0);
                @(negedge clk);
                @(posedge clk); #2 RSTn = 1'b1;
                aborted = 1'b1;
                return;
            end
        end
        s_valid = 1'b0;
        start   = 1'b0;
        chk({tag, "_sent"}, 32'(sent), 32'(FB));
    endtask

    task automatic run_frame(input int mode, input int poke_at, input int rst_at,
                             input int extra, input string tag);
        bit aborted;
        int budget;
        int bad;
        clear_all(extra, FB);
        send_frame(mode, poke_at, rst_at, tag, aborted);
        if (aborted) return;
        budget = 0;
        while (done_cnt == 0 && budget < 3000) begin
            @(negedge clk);
            budget++;
        end
        chk({tag, "_done_seen"}, 32'(done_cnt > 0), 32'd1);
        repeat (20) @(negedge clk);

        chk({tag, "_dec_len"}, 32'(dec_q.size()), 32'(FB + TB));
        bad = 0;
        for (int i = 0; i < dec_q.size(); i++) begin
            if (i < exp_syms.size()) begin
                if (dec_q[i] !== exp_syms[i]) bad++;
            end else if (dec_q[i] !== 2'b00) begin
                bad++;
            end
        end
        chk({tag, "_dec_data"}, 32'(bad), 32'd0);
        chk({tag, "_latency"}, 32'(lat_bad), 32'd0);
        chk({tag, "_m_cnt"}, 32'(got.size()), 32'(FB));
        bad = 0;
        for (int i = 0; i < got.size() && i < exp_syms.size(); i++)
            if (got[i] != (exp_syms[i][0] ^ exp_syms[i][1])) bad++;
        chk({tag, "_m_bits"}, 32'(bad), 32'd0);
        chk({tag, "_m_last_cnt"}, 32'(last_cnt), 32'd1);
        chk({tag, "_m_last_idx"}, 32'(last_idx), 32'(FB));
        chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
        chk({tag, "_done_after_last"}, 32'(done_cyc > last_cyc), 32'd1);
        chk({tag, "_busy_end"}, 32'(busy), 32'd0);
        if (mode == 0) chk({tag, "_run"}, 32'(max_run), 32'(FB + TB));
    endtask

    initial begin
        clear_all(0, FB);
        RSTn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs",
            32'({s_ready, dec_in_valid, dec_in, m_valid, m_data, m_last, busy, done, err_timeout}),
            32'd0);
        RSTn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_ready", 32'(s_ready), 32'd0);

        run_frame(0, -1,  -1, 0, "b2b");
        run_frame(1, -1,  -1, 0, "gap");
        run_frame(2, 100, -1, 0, "poke");
        run_frame(2, -1, 200, 0, "rst");
        run_frame(0, -1,  -1, 0, "post_rst");
        run_frame(1, -1,  -1, 8, "extra");

`ifdef VITERBI_FRAME_TIMEOUT_EN
        begin
            bit aborted;
            int budget;
            clear_all(0, 300);
            send_frame(0, -1, -1, "wdog", aborted);
            budget = 0;
            while (err_cnt == 0 && budget < 6000) begin
                @(negedge clk);
                budget++;
            end
            repeat (5) @(negedge clk);
            chk("wdog_err_cnt", 32'(err_cnt), 32'd1);
            chk("wdog_delay", 32'(err_cyc - dec_last_cyc), 32'd4096);
            chk("wdog_no_done", 32'(done_cnt), 32'd0);
            chk("wdog_busy", 32'(busy), 32'd0);
            chk("wdog_m_cnt", 32'(got.size()), 32'd300);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
